// File: rtl/nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem_pkg.sv
// Shared definitions for the OCI debug-memory block.
// Holds the default RAM address width, the bit positions of the
// fields carried in the 38-bit JTAG data word (jdo), the CPU-side FSM
// state type, and a helper that packs the monitor status word.
package nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem_pkg;

  localparam int DEF_ADDR_W   = 8;   // debug RAM depth = 2**DEF_ADDR_W words
  localparam int ADDR_LSB     = 17;  // jdo[24:17] carries the word address
  localparam int ADDR_FIELD_W = 8;
  localparam int CLR_BIT      = 34;  // ocimem_a: clear ready/error flags
  localparam int RD_BIT       = 35;  // ocimem_a: read at the new address
  localparam int WDATA_LSB    = 3;   // ocimem_b: jdo[34:3] is write data

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } cpu_state_e;

  function automatic logic [31:0] status_word(input logic err, input logic rdy);
    return {30'b0, err, rdy};
  endfunction

endpackage

// File: rtl/nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem_if.sv
// CPU-side Avalon-MM bus for the debug memory.
// avs_address MSB selects the two-bit status register window; the low
// ADDR_W bits address the RAM. avs_readdata is valid while a read is
// asserted and avs_waitrequest is low.
interface nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem_if
  import nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [ADDR_W:0] avs_address;
  logic            avs_read;
  logic            avs_write;
  logic [31:0]     avs_writedata;
  logic [3:0]      avs_byteenable;
  logic [31:0]     avs_readdata;
  logic            avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem_ram.sv
// Single-port debug RAM, 2**ADDR_W x 32, byte-enable writes,
// synchronous read with one cycle of latency.
// Ports: clk; re/we request strobes (never both); be byte lanes;
// addr word address; wdata write data; rdata registered read data
// (holds its value when re is low).
module nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              re,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  // One narrow array per byte lane keeps byte-enable writes simple to infer.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we && be[gi]) mem[addr] <= wdata[8*gi +: 8];
      if (re)           rd_q      <= mem[addr];
    end

    assign rdata[8*gi +: 8] = rd_q;
  end
endmodule

// File: rtl/nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem.sv
// System-clock OCI debug memory stage.
// JTAG side: ocimem_a loads the address (optionally clearing flags and
// reading), ocimem_b writes jdo[34:3], no_action reads; reads land in
// MonDReg two cycles after the strobe and the address post-increments.
// CPU side: Avalon slave (avs) sharing the RAM port; JTAG has priority.
// Ports: clk, reset_n (async, active low), jdo, three strobes,
// MonDReg / monitor_ready / monitor_error, avs (Avalon slave).
module nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem
  import nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter bit INIT_READY = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem_if.slave avs
);
  logic [ADDR_W-1:0] mon_a_reg_q, mon_a_reg_d;
  logic [31:0]       mon_d_reg_q, mon_d_reg_d;
  logic              monitor_ready_q, monitor_ready_d;
  logic              monitor_error_q, monitor_error_d;
  logic [31:0]       avs_readdata_q, avs_readdata_d;
  logic              jtag_rd_pend_q, jtag_rd_pend_d;
  cpu_state_e        state_q, state_d;

  logic              ram_re, ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic              wait_req;
  logic [31:0]       readdata_out;

  logic strobe_a, strobe_b, strobe_n, strobe_any;
  logic [ADDR_W-1:0] jdo_addr;
  logic unused_jdo_bits;

  // Priority a > b > no_action; any raw strobe still blocks the CPU.
  assign strobe_a   = take_action_ocimem_a;
  assign strobe_b   = take_action_ocimem_b & ~take_action_ocimem_a;
  assign strobe_n   = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign jdo_addr   = ADDR_W'(jdo[ADDR_LSB +: ADDR_FIELD_W]);
  assign unused_jdo_bits = ^{jdo[37:36], jdo[WDATA_LSB-1:0]};

  nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d         = state_q;
    mon_a_reg_d     = mon_a_reg_q;
    mon_d_reg_d     = mon_d_reg_q;
    monitor_ready_d = monitor_ready_q;
    monitor_error_d = monitor_error_q;
    avs_readdata_d  = avs_readdata_q;
    jtag_rd_pend_d  = 1'b0;
    ram_re          = 1'b0;
    ram_we          = 1'b0;
    ram_be          = 4'hF;
    ram_addr        = mon_a_reg_q;
    ram_wdata       = jdo[WDATA_LSB +: 32];
    wait_req        = 1'b0;
    readdata_out    = avs_readdata_q;

    // RAM output register holds the data of the read issued last cycle.
    if (jtag_rd_pend_q) mon_d_reg_d = ram_rdata;

    if (strobe_a) begin
      mon_a_reg_d = jdo_addr;
      if (jdo[RD_BIT]) begin
        ram_re         = 1'b1;
        ram_addr       = jdo_addr;
        jtag_rd_pend_d = 1'b1;
        mon_a_reg_d    = jdo_addr + 1'b1;
      end
    end else if (strobe_b) begin
      ram_we      = 1'b1;
      mon_a_reg_d = mon_a_reg_q + 1'b1;
    end else if (strobe_n) begin
      ram_re         = 1'b1;
      jtag_rd_pend_d = 1'b1;
      mon_a_reg_d    = mon_a_reg_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (avs.avs_read || avs.avs_write) begin
          if (avs.avs_address[ADDR_W]) begin
            // Status register window never touches the RAM: zero wait.
            if (avs.avs_write) begin
              if (avs.avs_writedata[0]) monitor_ready_d = 1'b1;
              if (avs.avs_writedata[1]) monitor_error_d = 1'b1;
            end else begin
              readdata_out = status_word(monitor_error_q, monitor_ready_q);
            end
          end else if (strobe_any) begin
            wait_req = 1'b1;
          end else if (avs.avs_write) begin
            ram_we    = 1'b1;
            ram_be    = avs.avs_byteenable;
            ram_addr  = avs.avs_address[ADDR_W-1:0];
            ram_wdata = avs.avs_writedata;
          end else begin
            ram_re   = 1'b1;
            ram_addr = avs.avs_address[ADDR_W-1:0];
            wait_req = 1'b1;
            state_d  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // RAM port is free here, so a JTAG strobe this cycle is serviced.
        wait_req       = 1'b1;
        avs_readdata_d = ram_rdata;
        state_d        = RD_DONE;
      end
      RD_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A JTAG clear beats a simultaneous CPU set.
    if (strobe_a && jdo[CLR_BIT]) begin
      monitor_ready_d = 1'b0;
      monitor_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a_reg_q     <= '0;
      mon_d_reg_q     <= '0;
      monitor_ready_q <= INIT_READY;
      monitor_error_q <= 1'b0;
      avs_readdata_q  <= '0;
      jtag_rd_pend_q  <= 1'b0;
      state_q         <= IDLE;
    end else begin
      mon_a_reg_q     <= mon_a_reg_d;
      mon_d_reg_q     <= mon_d_reg_d;
      monitor_ready_q <= monitor_ready_d;
      monitor_error_q <= monitor_error_d;
      avs_readdata_q  <= avs_readdata_d;
      jtag_rd_pend_q  <= jtag_rd_pend_d;
      state_q         <= state_d;
    end
  end

  assign MonDReg             = mon_d_reg_q;
  assign monitor_ready       = monitor_ready_q;
  assign monitor_error       = monitor_error_q;
  assign avs.avs_readdata    = readdata_out;
  assign avs.avs_waitrequest = wait_req;

  // Upstream issues at most one strobe per cycle.
  assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0({take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a}));

endmodule

// File: tb/tb_nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem.sv
// Scoreboard bench: stimulus tasks push expected CPU completions and
// expected MonDReg values into queues; a monitor pops and compares as
// the DUT presents them (CPU: read/write with waitrequest low; JTAG:
// two cycles after a read strobe).
module tb_nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem;
  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        tka = 1'b0, tkb = 1'b0, tkn = 1'b0;
  logic [31:0] mon_d;
  logic        mon_rdy, mon_err;

  nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem_if #(.ADDR_W(AW)) avs_if ();

  nios_with_sdram_nios2_gen2_0_cpu_debug_ocimem #(.ADDR_W(AW), .INIT_READY(1'b0)) u_dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (tka),
    .take_action_ocimem_b    (tkb),
    .take_no_action_ocimem_a (tkn),
    .MonDReg                 (mon_d),
    .monitor_ready           (mon_rdy),
    .monitor_error           (mon_err),
    .avs                     (avs_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    int          cycles;
  } cpu_exp_t;

  cpu_exp_t    cpu_q[$];
  logic [31:0] jtag_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    int       cyc;
    bit [1:0] pipe;
    cpu_exp_t e;
    cyc  = 0;
    pipe = 2'b00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cyc  = 0;
        pipe = 2'b00;
      end else begin
        if (pipe[1]) begin
          if (jtag_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL jtag_unexpected: MonDReg %h with no expectation", mon_d);
          end else begin
            check("MonDReg", mon_d, jtag_q.pop_front());
          end
        end
        pipe = {pipe[0], (tka & jdo[35]) | (tkn & ~tka & ~tkb)};
        if (avs_if.avs_read || avs_if.avs_write) begin
          cyc++;
          if (!avs_if.avs_waitrequest) begin
            if (cpu_q.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL cpu_unexpected: completion with no expectation");
            end else begin
              e = cpu_q.pop_front();
              check("cpu_cycles", 32'(cyc), 32'(e.cycles));
              if (e.is_rd) check("avs_readdata", avs_if.avs_readdata, e.data);
            end
            cyc = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic cpu_access(input bit wr, input logic [8:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input logic [31:0] exp_d, input int exp_cyc);
    cpu_exp_t e;
    int n;
    e.is_rd = !wr; e.data = exp_d; e.cycles = exp_cyc;
    cpu_q.push_back(e);
    @(posedge clk); #1;
    avs_if.avs_address    = addr;
    avs_if.avs_read       = !wr;
    avs_if.avs_write      = wr;
    avs_if.avs_writedata  = wd;
    avs_if.avs_byteenable = be;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (avs_if.avs_waitrequest && n < 20);
    if (avs_if.avs_waitrequest) begin
      n_cmp++; n_bad++;
      $display("FAIL cpu_timeout: addr %h still waiting after %0d cycles", addr, n);
    end
    @(posedge clk); #1;
    avs_if.avs_read  = 1'b0;
    avs_if.avs_write = 1'b0;
  endtask

  task automatic jtag_a(input logic [7:0] addr, input bit clr, input bit rd, input logic [31:0] exp_d);
    if (rd) jtag_q.push_back(exp_d);
    @(posedge clk); #1;
    jdo = '0;
    jdo[24:17] = addr;
    jdo[34] = clr;
    jdo[35] = rd;
    tka = 1'b1;
    @(posedge clk); #1;
    tka = 1'b0;
  endtask

  task automatic jtag_b(input logic [31:0] data);
    @(posedge clk); #1;
    jdo = '0;
    jdo[34:3] = data;
    tkb = 1'b1;
    @(posedge clk); #1;
    tkb = 1'b0;
  endtask

  task automatic jtag_n(input logic [31:0] exp_d);
    jtag_q.push_back(exp_d);
    @(posedge clk); #1;
    tkn = 1'b1;
    @(posedge clk); #1;
    tkn = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    avs_if.avs_address    = '0;
    avs_if.avs_read       = 1'b0;
    avs_if.avs_write      = 1'b0;
    avs_if.avs_writedata  = '0;
    avs_if.avs_byteenable = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_MonDReg", mon_d, 32'h0);
    check("rst_ready", {31'b0, mon_rdy}, 32'h0);
    check("rst_error", {31'b0, mon_err}, 32'h0);
    check("rst_waitrequest", {31'b0, avs_if.avs_waitrequest}, 32'h0);
    check("rst_readdata", avs_if.avs_readdata, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    cpu_access(1'b0, 9'h100, 32'h0, 4'hF, 32'h0, 1);          // status after reset

    // JTAG write then readback
    jtag_a(8'h10, 1'b0, 1'b0, 32'h0);
    jtag_b(32'hDEADBEEF);
    jtag_b(32'h12345678);
    jtag_a(8'h10, 1'b0, 1'b1, 32'hDEADBEEF);
    jtag_n(32'h12345678);

    // Address wrap 0xFF -> 0x00
    jtag_a(8'h00, 1'b0, 1'b0, 32'h0);
    jtag_b(32'h00000000);
    jtag_a(8'hFF, 1'b0, 1'b0, 32'h0);
    jtag_b(32'hA5A5A5A5);
    jtag_n(32'h00000000);
    jtag_a(8'hFF, 1'b0, 1'b1, 32'hA5A5A5A5);
    cpu_access(1'b0, 9'h0FF, 32'h0, 4'hF, 32'hA5A5A5A5, 3);

    // Collision: CPU read with ocimem_b in the same cycle
    jtag_a(8'h20, 1'b0, 1'b0, 32'h0);
    fork
      cpu_access(1'b0, 9'h010, 32'h0, 4'hF, 32'hDEADBEEF, 4);
      jtag_b(32'h0BADF00D);
    join
    jtag_a(8'h20, 1'b0, 1'b1, 32'h0BADF00D);
    cpu_access(1'b0, 9'h020, 32'h0, 4'hF, 32'h0BADF00D, 3);

    // JTAG read strobe during RD_WAIT
    jtag_a(8'h10, 1'b0, 1'b0, 32'h0);
    fork
      cpu_access(1'b0, 9'h011, 32'h0, 4'hF, 32'h12345678, 3);
      begin @(posedge clk); jtag_n(32'hDEADBEEF); end
    join

    // CPU RAM write stalled one cycle by a JTAG strobe
    fork
      cpu_access(1'b1, 9'h040, 32'h11223344, 4'hF, 32'h0, 2);
      jtag_a(8'h40, 1'b0, 1'b0, 32'h0);
    join
    jtag_n(32'h11223344);

    // Byte enables
    jtag_a(8'h30, 1'b0, 1'b0, 32'h0);
    jtag_b(32'h00000000);
    cpu_access(1'b1, 9'h030, 32'hFFFFFFFF, 4'b0101, 32'h0, 1);
    jtag_a(8'h30, 1'b0, 1'b1, 32'h00FF00FF);
    cpu_access(1'b0, 9'h030, 32'h0, 4'hF, 32'h00FF00FF, 3);

    // Flags
    cpu_access(1'b1, 9'h100, 32'h3, 4'hF, 32'h0, 1);
    cpu_access(1'b0, 9'h100, 32'h0, 4'hF, 32'h3, 1);
    fork
      cpu_access(1'b1, 9'h100, 32'h1, 4'hF, 32'h0, 1);
      jtag_a(8'h00, 1'b1, 1'b0, 32'h0);
    join
    cpu_access(1'b0, 9'h100, 32'h0, 4'hF, 32'h0, 1);
    cpu_access(1'b1, 9'h100, 32'h2, 4'hF, 32'h0, 1);
    cpu_access(1'b0, 9'h100, 32'h0, 4'hF, 32'h2, 1);
    jtag_a(8'h00, 1'b1, 1'b0, 32'h0);
    cpu_access(1'b0, 9'h100, 32'h0, 4'hF, 32'h0, 1);

    repeat (8) @(negedge clk);
    check("cpu_queue_drained", 32'(cpu_q.size()), 32'h0);
    check("jtag_queue_drained", 32'(jtag_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
